vrf_wb_arbiter: RTL and testbench

Write-port controller for the 32 x 256-bit vector register file. It shares the register file's single write port (WE3/A3/WD3) between two writeback sources: the vector ALU result and the Data Memory load return. It keeps a per-register pending-write scoreboard so the issue stage can detect RAW/WAW hazards. It also runs a clear sequencer that zeroes every register without asserting the register file's reset.

---
 rtl/vrf_wb_arbiter.sv | 101 ++++++++++
 tb/tb_vrf_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter: VRF write-port arbiter (ALU vs load), pending-write scoreboard and clear sequencer.
// Define VRF_WB_RR_EN for round-robin arbitration; otherwise loads win with fixed priority.
module vrf_wb_arbiter #(
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 256,
  parameter int ADDR_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [REG_WIDTH-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [REG_WIDTH-1:0] mem_data,
  output logic                 mem_ready,
  input  logic                 claim_valid,
  input  logic [ADDR_W-1:0]    claim_addr,
  output logic                 claim_ready,
  output logic [NUM_REGS-1:0]  busy,
  input  logic                 clr_start,
  output logic                 clr_done,
  output logic                 WE3,
  output logic [ADDR_W-1:0]    A3,
  output logic [REG_WIDTH-1:0] WD3
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic idle, mem_win, xfer;
  logic [ADDR_W-1:0] wb_addr;
  logic [REG_WIDTH-1:0] wb_data;
  logic [NUM_REGS-1:0] wb_oh, claim_oh, commit_oh;
  assign idle = state == IDLE;
`ifdef VRF_WB_RR_EN
  logic rr_mem;
  assign mem_win = mem_valid && (!alu_valid || rr_mem);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_mem <= 1'b1;
    else if (xfer) rr_mem <= alu_ready;
`else
  assign mem_win = mem_valid;
`endif
  assign mem_ready = idle && mem_win;
  assign alu_ready = idle && alu_valid && !mem_win;
  assign xfer      = mem_ready || alu_ready;
  assign wb_addr   = mem_ready ? mem_addr : alu_addr;
  assign wb_data   = mem_ready ? mem_data : alu_data;
  // One-hot decodes shift out to zero for addresses >= NUM_REGS, which makes them no-ops.
  assign wb_oh     = NUM_REGS'(1) << wb_addr;
  assign claim_oh  = NUM_REGS'(1) << claim_addr;
  assign commit_oh = WE3 ? NUM_REGS'(1) << A3 : '0;
  assign claim_ready = idle && claim_valid && !(|(busy & claim_oh));
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (clr_start) begin
        state_nx = CLEAR;
        cnt_nx = '0;
      end
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        state_nx = cnt == ADDR_W'(NUM_REGS - 1) ? DONE : CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // A claim landing on the same edge as the commit to that register wins (new owner).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WE3 <= 1'b0;
      A3 <= '0;
      WD3 <= '0;
      busy <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= state == DONE;
      busy <= state == DONE ? '0 : (busy & ~commit_oh) | (claim_ready ? claim_oh : '0);
      if (state == CLEAR) begin
        WE3 <= 1'b1;
        A3 <= cnt;
        WD3 <= '0;
      end else begin
        WE3 <= xfer && |wb_oh;
        if (xfer) begin
          A3 <= wb_addr;
          WD3 <= wb_data;
        end
      end
    end
endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// tb_vrf_wb_arbiter: directed plus randomized stimulus against a cycle-window reference model.
// NUM_REGS=24 so that addresses 24..31 exercise the out-of-range path.
module tb_vrf_wb_arbiter;
  localparam int NR = 24;
  localparam int W  = 256;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic alu_valid, mem_valid, claim_valid, clr_start;
  logic [AW-1:0] alu_addr, mem_addr, claim_addr;
  logic [W-1:0] alu_data, mem_data;
  logic alu_ready, mem_ready, claim_ready, clr_done, WE3;
  logic [NR-1:0] busy;
  logic [AW-1:0] A3;
  logic [W-1:0] WD3;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int cs = -1000;
  logic [NR-1:0] busy_m;
  bit fav_mem, e_we;
  logic [AW-1:0] e_a;
  logic [W-1:0] e_d;
  always #5 clk = ~clk;
  vrf_wb_arbiter #(.NUM_REGS(NR), .REG_WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .claim_ready(claim_ready),
    .busy(busy), .clr_start(clr_start), .clr_done(clr_done),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic drv(input bit av, input int aa, input logic [W-1:0] ad, input bit mv, input int ma,
                     input logic [W-1:0] md, input bit cv, input int ca, input bit st);
    alu_valid = av;
    alu_addr = AW'(aa);
    alu_data = ad;
    mem_valid = mv;
    mem_addr = AW'(ma);
    mem_data = md;
    claim_valid = cv;
    claim_addr = AW'(ca);
    clr_start = st;
  endtask
  task automatic model_reset();
    busy_m = '0;
    fav_mem = 1'b1;
    e_we = 1'b0;
    cs = -1000;
  endtask
  task automatic do_reset();
    drv(0, 0, '0, 0, 0, '0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("rst_WE3", WE3, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  // k = cycles since the accepted clr_start: blocked for k in 1..NR+1, zero writes of
  // address k-2 for k in 2..NR+1, clr_done and cleared busy at k = NR+2.
  task automatic step();
    bit idle, mwin, mw, aw, cw, st;
    int k;
    logic [AW-1:0] wa;
    logic [W-1:0] wd;
    #1;
    k = cyc - cs;
    idle = !(k >= 1 && k <= NR + 1);
`ifdef VRF_WB_RR_EN
    mwin = mem_valid && (!alu_valid || fav_mem);
`else
    mwin = mem_valid;
`endif
    mw = idle && mwin;
    aw = idle && alu_valid && !mwin;
    cw = idle && claim_valid && (claim_addr >= NR || !busy_m[claim_addr]);
    st = idle && clr_start;
    wa = mw ? mem_addr : alu_addr;
    wd = mw ? mem_data : alu_data;
    check("mem_ready", mem_ready, mw);
    check("alu_ready", alu_ready, aw);
    check("claim_ready", claim_ready, cw);
    @(posedge clk);
    #1;
    cyc++;
    k = cyc - cs;
    if (e_we) busy_m[e_a] = 1'b0;
    if (cw && claim_addr < NR) busy_m[claim_addr] = 1'b1;
    if (k == NR + 2) busy_m = '0;
    e_we = 1'b0;
    if (mw || aw) begin
      fav_mem = aw;
      if (wa < NR) begin
        e_we = 1'b1;
        e_a = wa;
        e_d = wd;
      end
    end
    if (k >= 2 && k <= NR + 1) begin
      e_we = 1'b1;
      e_a = AW'(k - 2);
      e_d = '0;
    end
    check("WE3", WE3, e_we);
    if (e_we) begin
      check("A3", A3, e_a);
      check("WD3", WD3, e_d);
    end
    check("busy", busy, busy_m);
    check("clr_done", clr_done, k == NR + 2);
    if (st) cs = cyc - 1;
  endtask
  task automatic idle_steps(input int n);
    drv(0, 0, '0, 0, 0, '0, 0, 0, 0);
    repeat (n) step();
  endtask
  initial begin
    logic [W-1:0] d;
    drv(0, 0, '0, 0, 0, '0, 0, 0, 0);
    #2;
    do_reset();
    d = 256'h8;
    drv(1, 5, d, 0, 0, '0, 0, 0, 0);
    step();
    idle_steps(2);
    repeat (4) begin
      drv(1, 6, rnd_vec(), 1, 7, rnd_vec(), 0, 0, 0);
      step();
    end
    idle_steps(2);
    drv(0, 0, '0, 0, 0, '0, 1, 7, 0);
    step();
    drv(0, 0, '0, 0, 0, '0, 1, 7, 0);
    step();
    drv(0, 0, '0, 1, 7, rnd_vec(), 0, 0, 0);
    step();
    idle_steps(2);
    drv(0, 0, '0, 1, 9, rnd_vec(), 0, 0, 0);
    step();
    drv(0, 0, '0, 0, 0, '0, 1, 9, 0);
    step();
    idle_steps(2);
    drv(1, 2, rnd_vec(), 0, 0, '0, 0, 0, 1);
    step();
    drv(1, 4, rnd_vec(), 1, 5, rnd_vec(), 1, 11, 0);
    repeat (NR + 3) step();
    drv(1, 26, rnd_vec(), 0, 0, '0, 0, 0, 0);
    step();
    drv(0, 0, '0, 1, 30, rnd_vec(), 1, 28, 0);
    step();
    idle_steps(2);
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 1), $urandom_range(0, 31), rnd_vec(), $urandom_range(0, 1),
          $urandom_range(0, 31), rnd_vec(), $urandom_range(0, 1), $urandom_range(0, 31),
          $urandom_range(0, 49) == 0);
      step();
    end
    idle_steps(NR + 3);
    drv(0, 0, '0, 0, 0, '0, 0, 0, 1);
    step();
    idle_steps(13);
    check("mid_clear_A3", A3, 12);
    do_reset();
    drv(1, 3, rnd_vec(), 0, 0, '0, 0, 0, 0);
    step();
    idle_steps(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
